// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and defaults for the fetch PC unit and its neighbours.
package fetch_pc_unit_pkg;

   localparam int PC_WIDTH_DEF = 10;
   localparam int LUT_AW_DEF   = 4;
   localparam int CNT_W        = 16;

   // Sequencer states of the fetch unit
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

   // ALU operation encodings shared with the execute stage
   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SLT  = 3'd5,
      ALU_CMPEQ = 3'd6,
      ALU_NOP  = 3'd7
   } alu_op_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_lut.sv
// Branch-target table: one synchronous write port, one combinational read
// port. A read of the entry being written in the same cycle returns the old
// contents, since the array only changes on the clock edge.
module branch_lut #(
   parameter int AW = 4,
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DEPTH-1:0][DW-1:0] mem;

   // Table storage; reset clears every target to address zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read of the currently stored target
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter sequencer: IDLE/RUN/DONE control, branch redirection
// through a target table, and a saturating retired-instruction counter.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int PC_WIDTH = PC_WIDTH_DEF,
   parameter int LUT_AW   = LUT_AW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [PC_WIDTH-1:0] start_addr,
   input  logic                stall,
   input  logic                halt_req,
   input  logic                branch_en,
   input  logic                jump,
   input  logic [LUT_AW-1:0]   target_idx,
   input  logic                lut_we,
   input  logic [LUT_AW-1:0]   lut_waddr,
   input  logic [PC_WIDTH-1:0] lut_wdata,
   output logic [PC_WIDTH-1:0] pc,
   output logic                fetch_valid,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    instr_count
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [PC_WIDTH-1:0] lut_target;
   logic                launch;
   logic                advance;
   logic                taken;

   branch_lut #(
      .AW (LUT_AW),
      .DW (PC_WIDTH)
   ) u_lut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lut_we),
      .waddr (lut_waddr),
      .wdata (lut_wdata),
      .raddr (target_idx),
      .rdata (lut_target)
   );

   // Qualifiers: control inputs are only meaningful on a non-stalled RUN cycle
   always_comb begin
      launch  = (state_q == IDLE) && start;
      advance = (state_q == RUN) && !stall;
      taken   = advance && !halt_req && branch_en && jump;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start is only honoured from IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (!stall && halt_req) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded straight from state
   always_comb begin
      busy        = (state_q == RUN);
      fetch_valid = (state_q == RUN);
      done        = (state_q == DONE);
   end

   // Next PC: halt holds, a taken branch redirects, otherwise sequential
   always_comb begin
      pc_d = pc_q;
      if (launch)                    pc_d = start_addr;
      else if (taken)                pc_d = lut_target;
      else if (advance && !halt_req) pc_d = pc_q + PC_WIDTH'(1);
   end

   // PC and retired count; both hold outside RUN so the final values stay readable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= '0;
         cnt_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (launch)       cnt_q <= '0;
         else if (advance) cnt_q <= sat_inc(cnt_q);
      end
   end

   assign pc          = pc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit against a behavioural model.
module tb_fetch_pc_unit;

   localparam int PW = 10;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [PW-1:0] start_addr;
   logic          stall, halt_req, branch_en, jump;
   logic [AW-1:0] target_idx;
   logic          lut_we;
   logic [AW-1:0] lut_waddr;
   logic [PW-1:0] lut_wdata;
   logic [PW-1:0] pc;
   logic          fetch_valid, busy, done;
   logic [15:0]   instr_count;

   int nvec = 0;
   int nerr = 0;

   // Behavioural model: plain integers and a flag per phase
   int m_pc;
   int m_cnt;
   bit m_run;
   bit m_done;
   int m_lut [1 << AW];

   fetch_pc_unit #(.PC_WIDTH(PW), .LUT_AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .stall(stall), .halt_req(halt_req), .branch_en(branch_en), .jump(jump),
      .target_idx(target_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
      .lut_wdata(lut_wdata), .pc(pc), .fetch_valid(fetch_valid), .busy(busy),
      .done(done), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
      for (int i = 0; i < (1 << AW); i++) m_lut[i] = 0;
   endtask

   // One clock edge worth of architectural behaviour
   task automatic model_edge();
      int tgt;
      if (!rst_n) return;
      tgt = m_lut[target_idx];
      if (m_done) begin
         m_done = 0;
      end else if (!m_run) begin
         if (start) begin m_run = 1; m_pc = start_addr; m_cnt = 0; end
      end else if (!stall) begin
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (halt_req) begin m_run = 0; m_done = 1; end
         else if (branch_en && jump) m_pc = tgt;
         else m_pc = (m_pc + 1) % (1 << PW);
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk_val(input string tag, input int got, input int exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      nvec++;
      assert (pc === PW'(m_pc)) else begin
         nerr++; $error("FAIL %s pc got %0h exp %0h", tag, pc, m_pc);
      end
      nvec++;
      assert (instr_count === 16'(m_cnt)) else begin
         nerr++; $error("FAIL %s instr_count got %0h exp %0h", tag, instr_count, m_cnt);
      end
      nvec++;
      assert (busy === m_run) else begin
         nerr++; $error("FAIL %s busy got %b exp %b", tag, busy, m_run);
      end
      nvec++;
      assert (fetch_valid === m_run) else begin
         nerr++; $error("FAIL %s fetch_valid got %b exp %b", tag, fetch_valid, m_run);
      end
      nvec++;
      assert (done === m_done) else begin
         nerr++; $error("FAIL %s done got %b exp %b", tag, done, m_done);
      end
   endtask

   task automatic clear_inputs();
      start = 0; start_addr = '0; stall = 0; halt_req = 0; branch_en = 0;
      jump = 0; target_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
   endtask

   task automatic rand_inputs();
      start      = ($urandom_range(0, 7) == 0);
      start_addr = PW'($urandom);
      stall      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 24) == 0);
      branch_en  = ($urandom_range(0, 2) == 0);
      jump       = 1'($urandom);
      target_idx = AW'($urandom);
      lut_we     = ($urandom_range(0, 4) == 0);
      lut_waddr  = AW'($urandom);
      lut_wdata  = PW'($urandom);
   endtask

   task automatic lut_load(input int idx, input int val);
      lut_we = 1; lut_waddr = AW'(idx); lut_wdata = PW'(val);
      cyc(); chk_all("lut_load");
      lut_we = 0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      model_reset();
      #3;
      chk_all("reset");
      chk_val("reset_pc", pc, 0);
      #4 rst_n = 1;

      lut_load(3, 'h040);
      lut_load(2, 'h055);
      lut_load(4, 'h010);
      lut_load(5, 'h020);

      // free run from 5
      start = 1; start_addr = 10'd5;
      cyc(); chk_all("start"); chk_val("start_pc", pc, 5);
      start = 0;
      for (int i = 1; i <= 4; i++) begin
         cyc(); chk_all("free_run"); chk_val("free_pc", pc, 5 + i);
      end
      chk_val("free_cnt", instr_count, 4);

      // start while RUN is ignored; halt finishes
      start = 1; start_addr = 10'h3AA; halt_req = 1;
      cyc(); chk_all("halt1"); chk_val("halt1_done", done, 1); chk_val("halt1_pc", pc, 9);
      start = 0; halt_req = 0;
      cyc(); chk_all("idle1"); chk_val("idle1_done", done, 0);

      // taken and not-taken branches
      start = 1; start_addr = 10'h010;
      cyc(); chk_all("start2");
      start = 0; branch_en = 1; jump = 1; target_idx = 3;
      cyc(); chk_all("br_taken"); chk_val("br_taken_pc", pc, 'h040);
      target_idx = 4;
      cyc(); chk_all("br_back"); chk_val("br_back_pc", pc, 'h010);
      jump = 0;
      cyc(); chk_all("br_not"); chk_val("br_not_pc", pc, 'h011);

      // halt beats a taken branch at 0x20
      jump = 1; target_idx = 5;
      cyc(); chk_all("br_20"); chk_val("br_20_pc", pc, 'h020);
      halt_req = 1; target_idx = 3;
      cyc(); chk_all("halt_br"); chk_val("halt_br_done", done, 1); chk_val("halt_br_pc", pc, 'h020);
      clear_inputs();
      cyc(); chk_all("halt_idle"); chk_val("halt_idle_pc", pc, 'h020); chk_val("halt_idle_busy", busy, 0);

      // wrap and stall
      start = 1; start_addr = 10'h3FF;
      cyc(); chk_all("start_wrap");
      start = 0;
      cyc(); chk_all("wrap"); chk_val("wrap_pc", pc, 0);
      for (int i = 0; i < 3; i++) begin
         stall = 1; halt_req = 1'($urandom); branch_en = 1; jump = 1; target_idx = 3;
         cyc(); chk_all("stall"); chk_val("stall_pc", pc, 0); chk_val("stall_cnt", instr_count, 1);
      end
      clear_inputs();

      // same-cycle write and branch read of index 2
      lut_we = 1; lut_waddr = 2; lut_wdata = 10'h077;
      branch_en = 1; jump = 1; target_idx = 2;
      cyc(); chk_all("wr_rd_old"); chk_val("wr_rd_old_pc", pc, 'h055);
      lut_we = 0;
      cyc(); chk_all("wr_rd_new"); chk_val("wr_rd_new_pc", pc, 'h077);
      clear_inputs();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         cyc(); chk_all("rand");
      end
      clear_inputs();

      // asynchronous reset in the middle of RUN
      while (!m_run) begin
         start = 1; start_addr = PW'($urandom);
         cyc(); chk_all("rerun");
      end
      start = 0;
      cyc(); chk_all("pre_rst");
      #2 rst_n = 0;
      #1;
      model_reset();
      chk_all("async_rst"); chk_val("async_rst_pc", pc, 0); chk_val("async_rst_busy", busy, 0);
      cyc(); chk_all("rst_hold"); chk_val("rst_hold_done", done, 0);
      #3 rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         branch_en = 1; jump = 1; halt_req = 1'($urandom);
         cyc(); chk_all("post_rst_idle"); chk_val("post_rst_busy", busy, 0);
      end
      clear_inputs();
      start = 1; start_addr = 10'h100;
      cyc(); chk_all("restart"); chk_val("restart_pc", pc, 'h100);
      start = 0; branch_en = 1; jump = 1; target_idx = 3;
      cyc(); chk_all("cleared_lut"); chk_val("cleared_lut_pc", pc, 0);
      clear_inputs();
      cyc(); chk_all("final");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
